// File: rtl/pipeline_stall_sequencer.sv
// ID-stage hazard sequencer for the 5-stage RV32I pipeline: RAW scoreboard plus
// RUN/STALL/FLUSH/MEMWAIT arbitration of memory wait, taken branches and data hazards.
module pipeline_stall_sequencer #(
    parameter int WB_DEPTH     = 3,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [6:0]       id_opcode,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             branch_taken,
    input  logic             mem_wait,
    output logic             pc_load,
    output logic             if_id_load,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             issue,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        STALL   = 2'd1,
        FLUSH   = 2'd2,
        MEMWAIT = 2'd3
    } state_t;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;

    localparam logic [2:0] WB_LOAD    = 3'(WB_DEPTH);
    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

    state_t           state_q, state_d;
    logic [2:0]       pending_q [32];
    logic [2:0]       pending_d [32];
    logic [3:0]       flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic uses_rs1, uses_rs2, writes_rd, raw, frozen, in_flush;

    always_comb begin
        uses_rs1  = (id_opcode == OP_REG) || (id_opcode == OP_STORE) ||
                    (id_opcode == OP_BRANCH) || (id_opcode == OP_LOAD) ||
                    (id_opcode == OP_IMM);
        uses_rs2  = (id_opcode == OP_REG) || (id_opcode == OP_STORE) ||
                    (id_opcode == OP_BRANCH);
        writes_rd = ((id_opcode == OP_REG) || (id_opcode == OP_LOAD) ||
                     (id_opcode == OP_IMM)) && (id_rd != 5'd0);
        raw       = id_valid && ((uses_rs1 && (pending_q[id_rs1] != 3'd0)) ||
                                 (uses_rs2 && (pending_q[id_rs2] != 3'd0)));
    end

    // A MEMWAIT entered from FLUSH keeps its flush count and resumes flushing.
    always_comb begin
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        stall_count_d = stall_count_q;
        pc_load       = 1'b0;
        if_id_load    = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b1;
        issue         = 1'b0;
        frozen        = 1'b0;
        in_flush      = (state_q == FLUSH) ||
                        ((state_q == MEMWAIT) && (flush_cnt_q != 4'd0));

        if (mem_wait) begin
            frozen       = 1'b1;
            id_ex_bubble = 1'b0;
            state_d      = MEMWAIT;
        end else if (in_flush) begin
            pc_load     = 1'b1;
            if_id_load  = 1'b1;
            if_id_flush = 1'b1;
            if (branch_taken) begin
                flush_cnt_d = FLUSH_INIT;
            end else if (flush_cnt_q != 4'd0) begin
                flush_cnt_d = flush_cnt_q - 4'd1;
            end
            state_d = (flush_cnt_d != 4'd0) ? FLUSH : RUN;
        end else if (branch_taken) begin
            pc_load     = 1'b1;
            if_id_load  = 1'b1;
            if_id_flush = 1'b1;
            flush_cnt_d = FLUSH_INIT;
            state_d     = (FLUSH_INIT != 4'd0) ? FLUSH : RUN;
        end else if (raw) begin
            if (!(&stall_count_q)) begin
                stall_count_d = stall_count_q + 1'b1;
            end
            state_d = STALL;
        end else begin
            pc_load      = 1'b1;
            if_id_load   = 1'b1;
            id_ex_bubble = 1'b0;
            issue        = id_valid;
            state_d      = RUN;
        end

        if (reset) begin
            pc_load      = 1'b0;
            if_id_load   = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_bubble = 1'b1;
            issue        = 1'b0;
        end
    end

    // A fresh load of the issuing rd takes precedence over that entry's decrement.
    always_comb begin
        for (int r = 0; r < 32; r++) begin
            pending_d[r] = pending_q[r];
            if (!frozen && (pending_q[r] != 3'd0)) begin
                pending_d[r] = pending_q[r] - 3'd1;
            end
        end
        if (issue && writes_rd) begin
            pending_d[id_rd] = WB_LOAD;
        end
        pending_d[0] = 3'd0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= RUN;
            flush_cnt_q   <= 4'd0;
            stall_count_q <= '0;
            for (int r = 0; r < 32; r++) begin
                pending_q[r] <= 3'd0;
            end
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            stall_count_q <= stall_count_d;
            for (int r = 0; r < 32; r++) begin
                pending_q[r] <= pending_d[r];
            end
        end
    end

    assign state       = state_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_stall_sequencer.sv
// Directed bench for pipeline_stall_sequencer: RAW stalls, x0 handling, branch flush,
// memory freeze, counter saturation and asynchronous reset.
module tb_pipeline_stall_sequencer;

    localparam logic [6:0] OP_REG = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;

    logic        clock;
    logic        reset;
    logic        id_valid;
    logic [6:0]  id_opcode;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        branch_taken, mem_wait;
    logic        pc_load, if_id_load, if_id_flush, id_ex_bubble, issue;
    logic [1:0]  state;
    logic [15:0] stall_count;

    int totalChecks = 0;
    int badChecks   = 0;

    pipeline_stall_sequencer #(
        .WB_DEPTH    (3),
        .FLUSH_CYCLES(2),
        .CNT_W       (16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_opcode   (id_opcode),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rd       (id_rd),
        .branch_taken(branch_taken),
        .mem_wait    (mem_wait),
        .pc_load     (pc_load),
        .if_id_load  (if_id_load),
        .if_id_flush (if_id_flush),
        .id_ex_bubble(id_ex_bubble),
        .issue       (issue),
        .state       (state),
        .stall_count (stall_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        totalChecks++;
        if (actual !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic checkCtl(input string tag, input logic pc, input logic ifl,
                            input logic fl, input logic bub, input logic iss,
                            input logic [1:0] st);
        checkOutput({tag, ".pc_load"},      32'(pc_load),      32'(pc));
        checkOutput({tag, ".if_id_load"},   32'(if_id_load),   32'(ifl));
        checkOutput({tag, ".if_id_flush"},  32'(if_id_flush),  32'(fl));
        checkOutput({tag, ".id_ex_bubble"}, 32'(id_ex_bubble), 32'(bub));
        checkOutput({tag, ".issue"},        32'(issue),        32'(iss));
        checkOutput({tag, ".state"},        32'(state),        32'(st));
    endtask

    task automatic applyStimulus(input logic v, input logic [6:0] op,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic br, input logic mw);
        id_valid     = v;
        id_opcode    = op;
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_rd        = rd;
        branch_taken = br;
        mem_wait     = mw;
        #2;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
            tick();
        end
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        checkCtl("rst", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        checkOutput("rst.cnt", 32'(stall_count), 32'd0);
        tick();
        reset = 1'b0;

        // add x5,x1,x2 then sub x6,x5,x1: three stall cycles
        applyStimulus(1'b1, OP_REG, 5'd1, 5'd2, 5'd5, 1'b0, 1'b0);
        checkCtl("t1.add", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, OP_REG, 5'd5, 5'd1, 5'd6, 1'b0, 1'b0);
            checkCtl("t1.stall", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, (i == 0) ? 2'd0 : 2'd1);
            tick();
        end
        applyStimulus(1'b1, OP_REG, 5'd5, 5'd1, 5'd6, 1'b0, 1'b0);
        checkCtl("t1.go", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1);
        checkOutput("t1.cnt", 32'(stall_count), 32'd3);
        tick();
        checkOutput("t1.pend6", 32'(dut.pending_q[6]), 32'd3);
        checkOutput("t1.state", 32'(state), 32'd0);
        idle(3);

        // writes to x0 never create a hazard
        applyStimulus(1'b1, OP_IMM, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0);
        checkCtl("t2.addi", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0);
        tick();
        checkOutput("t2.pend0", 32'(dut.pending_q[0]), 32'd0);
        applyStimulus(1'b1, OP_REG, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0);
        checkCtl("t2.add", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0);
        tick();
        checkOutput("t2.cnt", 32'(stall_count), 32'd3);
        idle(3);
        checkOutput("t2.pend3", 32'(dut.pending_q[3]), 32'd0);

        // taken branch while stalled: two flush cycles, stalled sub is dropped
        applyStimulus(1'b1, OP_REG, 5'd1, 5'd2, 5'd5, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, OP_REG, 5'd5, 5'd1, 5'd6, 1'b0, 1'b0);
        checkCtl("t3.stall", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        tick();
        applyStimulus(1'b1, OP_REG, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0);
        checkCtl("t3.br", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1);
        tick();
        applyStimulus(1'b1, OP_REG, 5'd5, 5'd1, 5'd6, 1'b0, 1'b0);
        checkCtl("t3.flush", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2);
        tick();
        applyStimulus(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        checkCtl("t3.run", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        checkOutput("t3.cnt", 32'(stall_count), 32'd4);
        checkOutput("t3.pend6", 32'(dut.pending_q[6]), 32'd0);
        tick();

        // memory freeze with pending[5]=2; branch during freeze is ignored
        applyStimulus(1'b1, OP_REG, 5'd1, 5'd2, 5'd5, 1'b0, 1'b0);
        tick();
        idle(1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, (i == 2), 1'b1);
            checkCtl("t4.mw", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, (i == 0) ? 2'd0 : 2'd3);
            tick();
        end
        checkOutput("t4.pend5", 32'(dut.pending_q[5]), 32'd2);
        applyStimulus(1'b1, OP_REG, 5'd5, 5'd1, 5'd6, 1'b0, 1'b0);
        checkCtl("t4.rel", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3);
        tick();
        checkOutput("t4.dec", 32'(dut.pending_q[5]), 32'd1);
        applyStimulus(1'b1, OP_REG, 5'd5, 5'd1, 5'd6, 1'b0, 1'b0);
        checkCtl("t4.stall", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1);
        tick();
        applyStimulus(1'b1, OP_REG, 5'd5, 5'd1, 5'd6, 1'b0, 1'b0);
        checkCtl("t4.go", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1);
        checkOutput("t4.cnt", 32'(stall_count), 32'd6);
        tick();
        idle(3);

        // stall counter saturates at all-ones
        force dut.stall_count_q = 16'hFFFE;
        #1;
        release dut.stall_count_q;
        checkOutput("t5.preset", 32'(stall_count), 32'hFFFE);
        applyStimulus(1'b1, OP_REG, 5'd1, 5'd2, 5'd5, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, OP_REG, 5'd5, 5'd1, 5'd6, 1'b0, 1'b0);
            tick();
            checkOutput("t5.sat", 32'(stall_count), 32'hFFFF);
        end
        applyStimulus(1'b1, OP_REG, 5'd5, 5'd1, 5'd6, 1'b0, 1'b0);
        checkCtl("t5.go", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1);
        tick();
        idle(3);

        // asynchronous reset in the middle of a stall on x7
        applyStimulus(1'b1, OP_IMM, 5'd1, 5'd0, 5'd7, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, OP_REG, 5'd7, 5'd0, 5'd8, 1'b0, 1'b0);
        checkCtl("t6.stall", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        tick();
        checkOutput("t6.install", 32'(state), 32'd1);
        reset = 1'b1;
        #1;
        checkCtl("t6.rst", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        checkOutput("t6.cnt", 32'(stall_count), 32'd0);
        checkOutput("t6.pend7", 32'(dut.pending_q[7]), 32'd0);
        tick();
        reset = 1'b0;
        applyStimulus(1'b1, OP_REG, 5'd7, 5'd0, 5'd8, 1'b0, 1'b0);
        checkCtl("t6.go", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0);
        tick();

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
